// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: ALU opcodes,
// FSM state encoding and the row-major address helper.
// Imported by the index counter and the sequencer top.
package matmul_pkg;

   localparam logic [1:0] NO_OPERATION = 2'b00;
   localparam logic [1:0] MUL          = 2'b01;
   localparam logic [1:0] ADD          = 2'b10;
   localparam logic [1:0] SUB          = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_MUL   = 3'd2,
      S_ADD   = 3'd3,
      S_ACC   = 3'd4,
      S_WRITE = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   function automatic int unsigned row_major(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/matmul_alu_sequencer_if.sv
// Memory and ALU bus of the matrix-multiply sequencer.
// master: sequencer side (drives addresses, C write, ALU op/operands).
// slave: memory/ALU side (returns read data and the registered ALU result).
interface matmul_alu_sequencer_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_rdata;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_rdata;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_we;
   logic [1:0]    alu_control;
   logic [DW-1:0] alu_in1;
   logic [DW-1:0] alu_in2;
   logic [DW-1:0] alu_out;

   modport master (
      output a_addr, b_addr, c_addr, c_wdata, c_we, alu_control, alu_in1, alu_in2,
      input  a_rdata, b_rdata, alu_out
   );

   modport slave (
      input  a_addr, b_addr, c_addr, c_wdata, c_we, alu_control, alu_in1, alu_in2,
      output a_rdata, b_rdata, alu_out
   );
endinterface

// File: rtl/matmul_index_counter.sv
// i/j/k loop counters with last-k / last-element flags and registered addresses.
// Ports: clear/step_k/step_elem controls in; last_k, last_elem, a/b/c addresses out.
// Addresses are registered from the next-index values so they track the counters.
module matmul_index_counter
   import matmul_pkg::*;
#(
   parameter int N  = 3,
   parameter int AW = $clog2(N*N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          step_k,
   input  logic          step_elem,
   output logic          last_k,
   output logic          last_elem,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr,
   output logic [AW-1:0] c_addr
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] i, j, k;
   logic [IW-1:0] i_nx, j_nx, k_nx;

   assign last_k    = (k == LAST);
   assign last_elem = (i == LAST) && (j == LAST);

   always_comb begin
      i_nx = i;
      j_nx = j;
      k_nx = k;
      if (clear) begin
         i_nx = '0;
         j_nx = '0;
         k_nx = '0;
      end else if (step_k) begin
         k_nx = last_k ? '0 : k + 1'b1;
      end else if (step_elem) begin
         // after the final element the indices stay parked at N-1
         if (j != LAST) begin
            j_nx = j + 1'b1;
         end else if (i != LAST) begin
            j_nx = '0;
            i_nx = i + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i      <= '0;
         j      <= '0;
         k      <= '0;
         a_addr <= '0;
         b_addr <= '0;
         c_addr <= '0;
      end else begin
         i      <= i_nx;
         j      <= j_nx;
         k      <= k_nx;
         a_addr <= AW'(row_major(32'(i_nx), 32'(k_nx), N));
         b_addr <= AW'(row_major(32'(k_nx), 32'(j_nx), N));
         c_addr <= AW'(row_major(32'(i_nx), 32'(j_nx), N));
      end
   end
endmodule

// File: rtl/matmul_alu_sequencer.sv
// Computes C = A*B for NxN matrices on a shared MUL/ADD ALU, one k step per 4 cycles.
// Ports: start/busy/done control; bus (master) carries A/B reads, C writes, ALU op.
// ALU op and operands are decoded from the registered state; the rest is registered.
module matmul_alu_sequencer
   import matmul_pkg::*;
#(
   parameter int N  = 3,
   parameter int DW = 16,
   parameter int AW = $clog2(N*N)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done,
   matmul_alu_sequencer_if.master bus
);
   state_t        state;
   logic [DW-1:0] acc;
   logic [DW-1:0] c_wdata;
   logic          c_we;
   logic          last_k, last_elem;
   logic          clear;

   assign clear = (state == S_IDLE) && start;

   matmul_index_counter #(.N(N), .AW(AW)) u_idx (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .step_k    (state == S_ACC),
      .step_elem (state == S_WRITE),
      .last_k    (last_k),
      .last_elem (last_elem),
      .a_addr    (bus.a_addr),
      .b_addr    (bus.b_addr),
      .c_addr    (bus.c_addr)
   );

   assign bus.c_we    = c_we;
   assign bus.c_wdata = c_wdata;

   // MUL consumes memory data arriving one cycle after FETCH; ADD consumes
   // the product the ALU registered at the end of MUL.
   always_comb begin
      bus.alu_control = NO_OPERATION;
      bus.alu_in1     = '0;
      bus.alu_in2     = '0;
      case (state)
         S_MUL: begin
            bus.alu_control = MUL;
            bus.alu_in1     = bus.a_rdata;
            bus.alu_in2     = bus.b_rdata;
         end
         S_ADD: begin
            bus.alu_control = ADD;
            bus.alu_in1     = acc;
            bus.alu_in2     = bus.alu_out;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         acc     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         c_we    <= 1'b0;
         c_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= S_FETCH;
               end
            end
            S_FETCH: state <= S_MUL;
            S_MUL:   state <= S_ADD;
            S_ADD:   state <= S_ACC;
            S_ACC: begin
               acc <= bus.alu_out;
               if (last_k) begin
                  // write data is the freshly accumulated sum, same value acc takes
                  c_we    <= 1'b1;
                  c_wdata <= bus.alu_out;
                  state   <= S_WRITE;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_WRITE: begin
               c_we <= 1'b0;
               acc  <= '0;
               if (last_elem) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_alu_sequencer.sv
module tb_matmul_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] start_v;
   logic [1:0] busy_v;
   logic [1:0] done_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matmul_alu_sequencer_if #(.DW(16), .AW(2)) bus0 ();
   matmul_alu_sequencer_if #(.DW(16), .AW(4)) bus1 ();

   matmul_alu_sequencer #(.N(2), .DW(16), .AW(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .bus(bus0)
   );

   matmul_alu_sequencer #(.N(3), .DW(16), .AW(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .bus(bus1)
   );

   // memory contents per instance, row-major
   logic [15:0] am [2][9];
   logic [15:0] bm [2][9];
   logic [15:0] exp_c [9];

   // C write logs
   logic [15:0] wa0[$], wd0[$], wa1[$], wd1[$];

   // synchronous memories and registered ALU models
   always @(posedge clk) begin
      bus0.a_rdata <= am[0][bus0.a_addr];
      bus0.b_rdata <= bm[0][bus0.b_addr];
      bus1.a_rdata <= am[1][bus1.a_addr];
      bus1.b_rdata <= bm[1][bus1.b_addr];
      case (bus0.alu_control)
         2'b01: bus0.alu_out <= 16'(bus0.alu_in1 * bus0.alu_in2);
         2'b10: bus0.alu_out <= bus0.alu_in1 + bus0.alu_in2;
         2'b11: bus0.alu_out <= bus0.alu_in1 - bus0.alu_in2;
         default: ;
      endcase
      case (bus1.alu_control)
         2'b01: bus1.alu_out <= 16'(bus1.alu_in1 * bus1.alu_in2);
         2'b10: bus1.alu_out <= bus1.alu_in1 + bus1.alu_in2;
         2'b11: bus1.alu_out <= bus1.alu_in1 - bus1.alu_in2;
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (bus0.c_we) begin
         wa0.push_back(16'(bus0.c_addr));
         wd0.push_back(bus0.c_wdata);
      end
      if (bus1.c_we) begin
         wa1.push_back(16'(bus1.c_addr));
         wd1.push_back(bus1.c_wdata);
      end
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int log_size(input int u);
      return (u == 0) ? wa0.size() : wa1.size();
   endfunction

   // Reference: C[r][c] = sum_k A[r][k]*B[k][c], modulo 2^16
   function automatic logic [15:0] ref_c(input int u, input int n, input int r, input int c);
      longint s = 0;
      for (int k = 0; k < n; k++)
         s += longint'(am[u][r*n+k]) * longint'(bm[u][k*n+c]);
      return 16'(s % 65536);
   endfunction

   function automatic logic [8:0][15:0] m9(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
      logic [8:0][15:0] m;
      m[0] = 16'(v0); m[1] = 16'(v1); m[2] = 16'(v2);
      m[3] = 16'(v3); m[4] = 16'(v4); m[5] = 16'(v5);
      m[6] = 16'(v6); m[7] = 16'(v7); m[8] = 16'(v8);
      return m;
   endfunction

   task automatic run_to_done(input int u, input bit hold, input bit poke, input int cyc0,
                              output int cyc, output bit got);
      cyc = cyc0;
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
         @(negedge clk);
         if (!hold) start_v[u] = poke && (cyc == 20);
         if (busy_v[u]) cyc++;
         if (done_v[u]) got = 1'b1;
      end
   endtask

   task automatic check_writes(input int u, input int n, input int base, input string tag);
      logic [15:0] a, d;
      chk({tag, "_wr_count"}, log_size(u) - base, n*n);
      for (int idx = 0; idx < n*n; idx++) begin
         if (base + idx < log_size(u)) begin
            a = (u == 0) ? wa0[base+idx] : wa1[base+idx];
            d = (u == 0) ? wd0[base+idx] : wd1[base+idx];
            chk({tag, "_c_addr"}, a, idx);
            chk({tag, "_c_data"}, d, exp_c[idx]);
         end
      end
   endtask

   task automatic full_run(input int u, input bit poke, input string tag);
      int n, cyc, base;
      bit got;
      n = (u == 0) ? 2 : 3;
      base = log_size(u);
      start_v[u] = 1'b1;
      run_to_done(u, 1'b0, poke, 0, cyc, got);
      chk({tag, "_done_seen"}, got, 1);
      chk({tag, "_busy_cycles"}, cyc, n*n*(4*n+1)+1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {busy_v[u], done_v[u]}, 0);
      check_writes(u, n, base, tag);
   endtask

   typedef struct {
      int               u;
      logic [8:0][15:0] a;
      logic [8:0][15:0] b;
      logic [8:0][15:0] c;
   } vec_t;

   vec_t vt[4];

   task automatic load_vec(input int v);
      for (int x = 0; x < 9; x++) begin
         am[vt[v].u][x] = vt[v].a[x];
         bm[vt[v].u][x] = vt[v].b[x];
         exp_c[x]       = vt[v].c[x];
      end
   endtask

   task automatic load_random(input int u);
      int n;
      n = (u == 0) ? 2 : 3;
      for (int x = 0; x < 9; x++) begin
         am[u][x] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         bm[u][x] = 16'($urandom);
      end
      for (int x = 0; x < 9; x++) exp_c[x] = 16'h0;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            exp_c[r*n+c] = ref_c(u, n, r, c);
   endtask

   initial begin
      logic [63:0] outs;
      int  cyc, base;
      bit  got, seen_we, hit;

      vt[0].u = 0; vt[0].a = m9(1, 2, 3, 4, 0, 0, 0, 0, 0);
      vt[0].b = m9(1, 0, 0, 1, 0, 0, 0, 0, 0);
      vt[0].c = m9(1, 2, 3, 4, 0, 0, 0, 0, 0);
      vt[1].u = 1; vt[1].a = m9(1, 2, 3, 4, 5, 6, 7, 8, 9);
      vt[1].b = m9(9, 8, 7, 6, 5, 4, 3, 2, 1);
      vt[1].c = m9(30, 24, 18, 84, 69, 54, 138, 114, 90);
      vt[2].u = 0; vt[2].a = m9(256, 256, 256, 256, 0, 0, 0, 0, 0);
      vt[2].b = m9(256, 256, 256, 256, 0, 0, 0, 0, 0);
      vt[2].c = m9(0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[3].u = 0; vt[3].a = m9(300, 300, 300, 300, 0, 0, 0, 0, 0);
      vt[3].b = m9(200, 200, 200, 200, 0, 0, 0, 0, 0);
      vt[3].c = m9(54464, 54464, 54464, 54464, 0, 0, 0, 0, 0);

      for (int x = 0; x < 9; x++) begin
         am[0][x] = '0; bm[0][x] = '0; am[1][x] = '0; bm[1][x] = '0;
      end
      rst_n = 1'b0;
      start_v = 2'b00;
      repeat (3) @(negedge clk);
      outs = {busy_v[0], done_v[0], bus0.c_we, bus0.a_addr, bus0.b_addr, bus0.c_addr,
              bus0.c_wdata, bus0.alu_in1, bus0.alu_in2, bus0.alu_control};
      chk("reset_outputs_n2", outs, 0);
      outs = {busy_v[1], done_v[1], bus1.c_we, bus1.a_addr, bus1.b_addr, bus1.c_addr,
              bus1.alu_in1, bus1.alu_in2, bus1.alu_control};
      chk("reset_outputs_n3", outs, 0);
      chk("reset_wdata_n3", bus1.c_wdata, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven vectors
      for (int v = 0; v < 4; v++) begin
         load_vec(v);
         full_run(vt[v].u, 1'b0, $sformatf("vec%0d", v));
         repeat (2) @(negedge clk);
      end

      // randomized runs against the reference model; one gets a start poke mid-run
      for (int r = 0; r < 4; r++) begin
         load_random(1);
         full_run(1, r == 1, $sformatf("rnd3_%0d", r));
      end
      for (int r = 0; r < 2; r++) begin
         load_random(0);
         full_run(0, r == 0, $sformatf("rnd2_%0d", r));
      end

      // reset during the ADD step of element 1
      load_vec(0);
      base = log_size(0);
      seen_we = 1'b0;
      hit = 1'b0;
      start_v[0] = 1'b1;
      for (int t = 0; t < 200 && !hit; t++) begin
         @(negedge clk);
         start_v[0] = 1'b0;
         if (bus0.c_we) seen_we = 1'b1;
         if (seen_we && !bus0.c_we && bus0.alu_control == 2'b10) hit = 1'b1;
      end
      chk("midrun_add_reached", hit, 1);
      chk("midrun_pre_writes", log_size(0) - base, 1);
      #1 rst_n = 1'b0;
      #1;
      outs = {busy_v[0], done_v[0], bus0.c_we, bus0.a_addr, bus0.b_addr, bus0.c_addr,
              bus0.c_wdata, bus0.alu_in1, bus0.alu_in2, bus0.alu_control};
      chk("midrun_reset_outputs", outs, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = log_size(0);
      repeat (40) @(negedge clk);
      chk("midrun_no_we_after", log_size(0) - base, 0);
      chk("midrun_stays_idle", busy_v[0], 0);
      full_run(0, 1'b0, "after_reset");

      // start held through a run: exactly one idle cycle before the next run
      load_vec(3);
      base = log_size(0);
      start_v[0] = 1'b1;
      run_to_done(0, 1'b1, 1'b0, 0, cyc, got);
      chk("hold_done_seen", got, 1);
      chk("hold_busy_cycles", cyc, 37);
      @(negedge clk);
      chk("hold_idle_gap", busy_v[0], 0);
      @(negedge clk);
      chk("hold_restart", busy_v[0], 1);
      chk("hold_restart_a_addr", bus0.a_addr, 0);
      check_writes(0, 2, base, "hold_run1");
      base = log_size(0);
      start_v[0] = 1'b0;
      run_to_done(0, 1'b0, 1'b0, 1, cyc, got);
      chk("hold2_done_seen", got, 1);
      chk("hold2_busy_cycles", cyc, 37);
      check_writes(0, 2, base, "hold_run2");

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matmul_alu_sequencer.md
Name: matmul_alu_sequencer

Overview:
Controller that computes one N×N matrix product C = A·B on the shared 16-bit MUL/ADD ALU. It walks the i/j/k loop nest and fetches operands from synchronous A and B memories. It issues MUL then ADD ops to the ALU, accumulates each dot product and writes the result into C memory. It sits between the top-level start/done control and the ALU plus the three matrix RAMs.

Parameters:
N, 3, matrix dimension (2..15)
DW, 16, data width; must match the ALU width
AW, $clog2(N*N), address width of the A, B and C memories (row-major)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last C element has been written
a_addr  out  AW  A read address = i*N+k
a_rdata  in  DW  A read data, valid 1 cycle after a_addr
b_addr  out  AW  B read address = k*N+j
b_rdata  in  DW  B read data, valid 1 cycle after b_addr
c_addr  out  AW  C write address = i*N+j
c_wdata  out  DW  C write data
c_we  out  1  C write strobe, one cycle per element
alu_control  out  2  00 NO_OPERATION, 01 MUL, 10 ADD, 11 SUB (never issued)
alu_in1  out  DW  ALU operand 1
alu_in2  out  DW  ALU operand 2
alu_out  in  DW  registered ALU result, valid 1 cycle after the op is issued

Behaviour:
- Reset (async, rst_n=0): state=IDLE; i=j=k=0; acc=0.
- Outputs during and after reset: busy, done, c_we, all addresses, c_wdata, alu_in1, alu_in2 = 0; alu_control=00.
- Reset mid-run abandons the run with no further c_we; a new start is needed.
- States: IDLE, FETCH, MUL, ADD, ACC, WRITE, DONE.
- IDLE:
  - alu_control=00.
  - On start=1: clear i, j, k and acc; go to FETCH.
- FETCH: drive a_addr and b_addr; alu_control=00; go to MUL.
- MUL: alu_control=01, alu_in1=a_rdata, alu_in2=b_rdata; go to ADD.
- ADD: alu_control=10, alu_in1=acc, alu_in2=alu_out (the product); go to ACC.
- ACC: acc<=alu_out; alu_control=00.
  - If k==N-1: k<=0, go to WRITE.
  - Else: k<=k+1, go to FETCH.
- WRITE: c_we=1, c_addr=i*N+j, c_wdata=acc; acc<=0.
  - If j<N-1: j<=j+1.
  - Else if i<N-1: j<=0, i<=i+1.
  - Next state is FETCH, or DONE after i=j=N-1.
- DONE: done=1 for this single cycle; go to IDLE.
- Latency: 4 cycles per k step, plus 1 WRITE cycle per element.
  - busy is high for exactly N²(4N+1)+1 cycles.
  - N=2 gives 37 cycles; N=3 gives 118 cycles.
- Arithmetic: modulo 2^DW. The ALU truncates products to DW bits, and acc wraps with no saturation or flag.
- start while busy: ignored.
- start held high: the new run begins on the IDLE cycle following DONE, so there is one idle cycle between runs.
- Address outputs are held registered between updates; they change only in FETCH and WRITE.
- zflag and ac_load from the ALU are not used by this block.

Decomposition:
- Package matmul_pkg:
  - ALU op constants NO_OPERATION=2'b00, MUL=2'b01, ADD=2'b10, SUB=2'b11.
  - State encoding constants for the seven states.
- Sub-module matmul_index_counter: the i/j/k nested counters with last-k and last-element flags and the three address computations.
- The sequencer holds the FSM, acc and the ALU operand muxes.

Test Plan:
- N=2; A=[[1,2],[3,4]], B=identity; pulse start -> C writes in order addr0..3 = 1,2,3,4; done exactly 37 cycles after the start edge; busy high 37 cycles.
- N=3; A=[[1,2,3],[4,5,6],[7,8,9]], B=[[9,8,7],[6,5,4],[3,2,1]] -> C = [[30,24,18],[84,69,54],[138,114,90]]; 9 c_we pulses; done at 118.
- N=2; A all 16'h0100, B all 16'h0100 -> each product truncates to 0, so every C element is 16'h0000.
- N=2; A all 300, B all 200 -> each C element = (2·60000) mod 65536 = 54464.
- Reset: assert rst_n=0 during the ADD state of element 1 -> all outputs 0 within the same cycle, no further c_we; re-start -> full correct run.
- start held high through a full run -> second run's FETCH occurs one IDLE cycle after DONE; start pulsed while busy -> no effect on cycle count or results.
